// File: rtl/pkt_source_pkg.sv
// Shared types and width helper for the pkt_source packet transmitter.
package pkt_source_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pkt_source_ram.sv
// Simple dual-port buffer: one write port, one synchronous read port whose
// output register holds its value while rd_en_i is low.
module pkt_source_ram #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 128,
    parameter int AW     = 7
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DWIDTH-1:0] rd_data_o
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output register doubles as the stream data register, so it is reset.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pkt_source.sv
// Avalon-ST packet source: buffers one packet, then replays it with SOP/EOP
// framing and backpressure. Define PKT_SOURCE_IDLE_GAP_EN for one idle cycle after EOP.
module pkt_source
    import pkt_source_pkg::*;
#(
    parameter int DWIDTH      = 64,
    parameter int MAX_PKT_LEN = 128
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              wr_valid_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              trunc_o
);

    localparam int PW = width_for(MAX_PKT_LEN);
    localparam int LW = width_for(MAX_PKT_LEN + 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   len_q, len_d;
    logic            valid_q, valid_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic            trunc_q, trunc_d;
    logic            ram_wr_en;
    logic            ram_rd_en;
    logic [PW-1:0]   ram_rd_addr;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            trunc_q  <= trunc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        trunc_d     = 1'b0;
        ram_wr_en   = 1'b0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = rd_ptr_q;

        case (state_q)
            FILL: begin
                if (wr_valid_i) begin
                    ram_wr_en = 1'b1;
                    wr_ptr_d  = wr_ptr_q + PW'(1);
                    if (wr_last_i || (wr_ptr_q == PW'(MAX_PKT_LEN - 1))) begin
                        state_d  = SEND;
                        len_d    = LW'(wr_ptr_q) + LW'(1);
                        wr_ptr_d = '0;
                        trunc_d  = !wr_last_i;
                    end
                end
            end
            SEND: begin
                if (!valid_q) begin
                    // Priming cycle: fetch word 0 so it appears with valid.
                    ram_rd_en   = 1'b1;
                    ram_rd_addr = '0;
                    valid_d     = 1'b1;
                    sop_d       = 1'b1;
                    eop_d       = (len_q == LW'(1));
                end else if (src_ready_i) begin
                    if (eop_q) begin
                        valid_d  = 1'b0;
                        sop_d    = 1'b0;
                        eop_d    = 1'b0;
                        rd_ptr_d = '0;
`ifdef PKT_SOURCE_IDLE_GAP_EN
                        state_d  = GAP;
`else
                        state_d  = FILL;
`endif
                    end else begin
                        // Fetch the next word on the same edge as the transfer.
                        ram_rd_en   = 1'b1;
                        ram_rd_addr = rd_ptr_q + PW'(1);
                        rd_ptr_d    = rd_ptr_q + PW'(1);
                        sop_d       = 1'b0;
                        eop_d       = ((LW'(rd_ptr_q) + LW'(2)) == len_q);
                    end
                end
            end
            GAP: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    pkt_source_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .AW     (PW)
    ) u_ram (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data_i),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (src_data_o)
    );

    assign wr_ready_o          = (state_q == FILL);
    assign src_valid_o         = valid_q;
    assign src_startofpacket_o = sop_q;
    assign src_endofpacket_o   = eop_q;
    assign trunc_o             = trunc_q;

endmodule
